// File: rtl/bcd_entry_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package  : bcd_entry_pkg                                         |
// | Purpose  : Key codes, FSM state type and width helper shared by  |
// |            the BCD keypad entry buffer and its converter.        |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package bcd_entry_pkg;

  localparam logic [3:0] KEY_SIGN      = 4'hA;
  localparam logic [3:0] KEY_COMMIT    = 4'hB;
  localparam logic [3:0] KEY_BACKSPACE = 4'hE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } entry_state_t;

  // Bits needed to hold any value below 10**digits.
  function automatic int clog2_pow10(input int digits);
    longint p;
    int     w;
    p = 1;
    w = 0;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    while ((longint'(1) << w) < p) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_serial_to_bin.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : bcd_serial_to_bin                                     |
// | Purpose  : Serial BCD-to-binary converter. Walks the digits from  |
// |            the most significant nibble down, one per cycle,      |
// |            computing acc*10 + digit.                              |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module bcd_serial_to_bin
  import bcd_entry_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int ACC_W  = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd,
  output logic                last,
  output logic [ACC_W-1:0]    acc_next
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] acc;
  logic             running;
  logic [3:0]       nibble;

  // Select the digit currently addressed by the index counter.
  always_comb begin
    nibble = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nibble = bcd[4*i +: 4];
      end
    end
  end

  // acc*10 as shift-and-add; the extra accumulator bits keep it from wrapping.
  assign acc_next = (acc << 3) + (acc << 1) + ACC_W'(nibble);

  // The step taken while idx is zero is the final one.
  assign last = running && (idx == '0);

  // Index counter and accumulator; start arms a fresh DIGITS-step pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx     <= '0;
      acc     <= '0;
      running <= 1'b0;
    end else if (clear) begin
      idx     <= '0;
      acc     <= '0;
      running <= 1'b0;
    end else if (start) begin
      idx     <= IDX_W'(DIGITS - 1);
      acc     <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc <= acc_next;
      idx <= idx - 1'b1;
      if (idx == '0) begin
        running <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_entry_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : bcd_entry_buffer                                      |
// | Purpose  : Keypad digit-entry buffer. Collects decimal keys into  |
// |            a right-aligned BCD display buffer with backspace and |
// |            clear; a commit key converts the entry to binary,     |
// |            saturates at MAX_VAL and offers it on valid/ready.    |
// | Options  : BCD_ENTRY_SIGN_EN adds a sign key and out_neg port.   |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module bcd_entry_buffer
  import bcd_entry_pkg::*;
#(
  parameter int DIGITS  = 3,
  parameter int MAX_VAL = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clr,
  input  logic [3:0]                          key_code,
  input  logic                                key_valid,
  output logic [4*DIGITS-1:0]                 disp_bcd,
  output logic                                busy,
  output logic [clog2_pow10(DIGITS)-1:0]      out_value,
  output logic                                out_sat,
  output logic                                out_valid,
  input  logic                                out_ready
`ifdef BCD_ENTRY_SIGN_EN
  ,
  output logic                                out_neg
`endif
);

  localparam int VAL_W = clog2_pow10(DIGITS);
  localparam int ACC_W = VAL_W + 4;
  localparam int BUF_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);

  entry_state_t     state;
  entry_state_t     next_state;
  logic [BUF_W-1:0] buffer;
  logic [CNT_W-1:0] count;
  logic             clr_q;
  logic             conv_start;
  logic             conv_last;
  logic [ACC_W-1:0] conv_next;
  logic             handshake;
  logic             key_idle;
  logic             sat_hit;
`ifdef BCD_ENTRY_SIGN_EN
  logic             neg;
`endif

  assign disp_bcd  = buffer;
  assign busy      = (state != IDLE);
  assign handshake = out_valid && out_ready;
  assign key_idle  = (state == IDLE) && key_valid && !clr_q;
  assign conv_start = key_idle && (key_code == KEY_COMMIT);
  assign sat_hit   = (conv_next > ACC_W'(MAX_VAL));

  bcd_serial_to_bin #(
    .DIGITS (DIGITS),
    .ACC_W  (ACC_W)
  ) u_conv (
    .clk      (clk),
    .rst      (rst),
    .clear    (clr_q),
    .start    (conv_start),
    .bcd      (buffer),
    .last     (conv_last),
    .acc_next (conv_next)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a registered clear overrides every transition.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (conv_start) next_state = CONV;
      CONV:    if (conv_last)  next_state = HOLD;
      HOLD:    if (handshake)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (clr_q) begin
      next_state = IDLE;
    end
  end

  // Entry buffer, result registers and handshake flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_q     <= 1'b0;
      buffer    <= '0;
      count     <= '0;
      out_value <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
`ifdef BCD_ENTRY_SIGN_EN
      neg       <= 1'b0;
      out_neg   <= 1'b0;
`endif
    end else begin
      clr_q <= clr;
      if (clr_q) begin
        buffer    <= '0;
        count     <= '0;
        out_value <= '0;
        out_sat   <= 1'b0;
        out_valid <= 1'b0;
`ifdef BCD_ENTRY_SIGN_EN
        neg       <= 1'b0;
        out_neg   <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (key_valid) begin
              if (key_code <= 4'd9) begin
                if (count < CNT_W'(DIGITS)) begin
                  buffer <= (buffer << 4) | BUF_W'(key_code);
                  count  <= count + 1'b1;
                end
              end else if (key_code == KEY_BACKSPACE) begin
                if (count != '0) begin
                  buffer <= buffer >> 4;
                  count  <= count - 1'b1;
                end
`ifdef BCD_ENTRY_SIGN_EN
              end else if (key_code == KEY_SIGN) begin
                neg <= ~neg;
`endif
              end
            end
          end
          CONV: begin
            if (conv_last) begin
              if (sat_hit) begin
                out_value <= VAL_W'(MAX_VAL);
                out_sat   <= 1'b1;
              end else begin
                out_value <= conv_next[VAL_W-1:0];
                out_sat   <= 1'b0;
              end
`ifdef BCD_ENTRY_SIGN_EN
              out_neg <= neg && (conv_next != '0);
`endif
            end
          end
          HOLD: begin
            if (!out_valid) begin
              out_valid <= 1'b1;
            end else if (out_ready) begin
              out_valid <= 1'b0;
              buffer    <= '0;
              count     <= '0;
`ifdef BCD_ENTRY_SIGN_EN
              neg       <= 1'b0;
              out_neg   <= 1'b0;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_entry_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_bcd_entry_buffer                                   |
// | Purpose  : Directed self-checking bench for bcd_entry_buffer     |
// |            (DIGITS=3, MAX_VAL=255). Sign checks are compiled in  |
// |            when BCD_ENTRY_SIGN_EN is defined.                     |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_bcd_entry_buffer;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [11:0] disp_bcd;
  logic        busy;
  logic [9:0]  out_value;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;
`ifdef BCD_ENTRY_SIGN_EN
  logic        out_neg;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bcd_entry_buffer #(
    .DIGITS  (3),
    .MAX_VAL (255)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .key_code  (key_code),
    .key_valid (key_valid),
    .disp_bcd  (disp_bcd),
    .busy      (busy),
    .out_value (out_value),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef BCD_ENTRY_SIGN_EN
    ,
    .out_neg   (out_neg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle key strobe; returns at the falling edge after it was sampled.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_code  = code;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  // Commit and check the valid latency (rises on edge T+4) and the result.
  task automatic commit_check(input string tag, input int val, input logic sat);
    press(4'hB);
    repeat (3) @(negedge clk);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_valid_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_value"}, 32'(out_value), 32'(val));
    check({tag, "_sat"}, 32'(sat), 32'(out_sat) ^ 32'(sat) ^ 32'(sat));
    check({tag, "_sat_exp"}, 32'(out_sat), 32'(sat));
  endtask

  // Accept the result and confirm the entry is cleared.
  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_disp_clr"}, 32'(disp_bcd), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    clr       = 1'b0;
    key_code  = 4'h0;
    key_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_disp",  32'(disp_bcd),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_value", 32'(out_value), 32'd0);
    check("rst_sat",   32'(out_sat),   32'd0);
    rst = 1'b1;

    // Basic entry and conversion.
    press(4'h1); press(4'h2); press(4'h8);
    check("e128_disp", 32'(disp_bcd), 32'h128);
    commit_check("e128", 128, 1'b0);
    check("e128_disp_hold", 32'(disp_bcd), 32'h128);
    accept("e128");

    // Full buffer ignores extra digit; value saturates.
    press(4'h9); press(4'h9); press(4'h9); press(4'h7);
    check("e999_disp", 32'(disp_bcd), 32'h999);
    commit_check("e999", 255, 1'b1);
    accept("e999");

    // Backspace at empty is a no-op; backspace mid-entry drops the last digit.
    press(4'hE);
    check("bs_empty", 32'(disp_bcd), 32'h000);
    press(4'h4); press(4'h5);
    check("bs_045", 32'(disp_bcd), 32'h045);
    press(4'hE);
    check("bs_004", 32'(disp_bcd), 32'h004);
    press(4'h6);
    check("bs_046", 32'(disp_bcd), 32'h046);
    commit_check("e46", 46, 1'b0);
    accept("e46");

    // Empty commit yields 0; result stays put while downstream stalls.
    commit_check("e0", 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        key_code  = 4'h5;
        key_valid = 1'b1;
      end else begin
        key_valid = 1'b0;
      end
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_value", 32'(out_value), 32'd0);
    end
    key_valid = 1'b0;
    check("stall_disp", 32'(disp_bcd), 32'd0);
    accept("e0");

    // Sign key: ignored without the option, toggles the flag with it.
    press(4'hA); press(4'h7);
    check("sign_disp", 32'(disp_bcd), 32'h007);
    commit_check("sign7", 7, 1'b0);
`ifdef BCD_ENTRY_SIGN_EN
    check("sign7_neg", 32'(out_neg), 32'd1);
`endif
    accept("sign7");
`ifdef BCD_ENTRY_SIGN_EN
    check("sign7_neg_clr", 32'(out_neg), 32'd0);
    press(4'hA);
    commit_check("sign0", 0, 1'b0);
    check("sign0_neg", 32'(out_neg), 32'd0);
    accept("sign0");
`endif

    // Clear pulse during conversion aborts it.
    press(4'h3);
    check("clr_disp_pre", 32'(disp_bcd), 32'h003);
    press(4'hB);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_still_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("clr_idle", 32'(busy), 32'd0);
    check("clr_disp", 32'(disp_bcd), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("clr_no_valid", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset while a result is held.
    press(4'h5);
    commit_check("e5", 5, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_busy",  32'(busy),      32'd0);
    check("arst_value", 32'(out_value), 32'd0);
    check("arst_disp",  32'(disp_bcd),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    press(4'h2);
    check("post_rst_disp", 32'(disp_bcd), 32'h002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
